grad_accum_cache: RTL

- Parametrised successor to the gradient buffer: a set-associative store with its lookup, accumulate and evict controller built in.
- Accepts (address, gradient) updates on a valid/ready stream and accumulates them per address with signed saturation.
- Emits an entry on a valid/ready eviction stream on any of: threshold crossing, update-count exhaustion, conflict replacement, or a bulk flush request.
- Sits between the gradient producer and the weight-update / memory write path.

---
 rtl/grad_cache_pkg.sv | 40 ++++
 rtl/grad_cache_store.sv | 73 +++++++
 rtl/grad_accum_cache.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/grad_cache_pkg.sv
// rtl/grad_cache_pkg.sv - shared types and saturating add for the gradient accumulation cache
package grad_cache_pkg;

    typedef enum logic [1:0] {
        EV_THRESH   = 2'd0,
        EV_MAXUPD   = 2'd1,
        EV_CONFLICT = 2'd2,
        EV_FLUSH    = 2'd3
    } ev_cause_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_FDONE
    } state_e;

    // Wide enough that any legal ACC_W sum fits before clamping.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/grad_cache_store.sv
// rtl/grad_cache_store.sv - set-associative entry arrays with whole-set read and per-set round-robin pointer
module grad_cache_store #(
    parameter int ADDR_W   = 32,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 8,
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    localparam int SET_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_W-1:0]    rd_set,
    output logic [NUM_WAYS-1:0] rd_valid,
    output logic [ADDR_W-1:0]   rd_tag [NUM_WAYS],
    output logic [ACC_W-1:0]    rd_acc [NUM_WAYS],
    output logic [CNT_W-1:0]    rd_cnt [NUM_WAYS],
    output logic [WAY_W-1:0]    rd_rr,
    input  logic                wr_en,
    input  logic [SET_W-1:0]    wr_set,
    input  logic [WAY_W-1:0]    wr_way,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_tag,
    input  logic [ACC_W-1:0]    wr_acc,
    input  logic [CNT_W-1:0]    wr_cnt,
    input  logic                rr_inc
);

    logic              valid_q [NUM_SETS][NUM_WAYS];
    logic [ADDR_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [ACC_W-1:0]  acc_q   [NUM_SETS][NUM_WAYS];
    logic [CNT_W-1:0]  cnt_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  rr_q    [NUM_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (wr_en) begin
                valid_q[wr_set][wr_way] <= wr_valid;
            end
            // Power-of-two way count makes the natural wrap the round-robin wrap.
            if (rr_inc) begin
                rr_q[wr_set] <= rr_q[wr_set] + WAY_W'(1);
            end
        end
    end

    // Payload is meaningless while the valid bit is clear, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_set][wr_way] <= wr_tag;
            acc_q[wr_set][wr_way] <= wr_acc;
            cnt_q[wr_set][wr_way] <= wr_cnt;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_valid[w] = valid_q[rd_set][w];
            rd_tag[w]   = tag_q[rd_set][w];
            rd_acc[w]   = acc_q[rd_set][w];
            rd_cnt[w]   = cnt_q[rd_set][w];
        end
        rd_rr = rr_q[rd_set];
    end

endmodule

// File: rtl/grad_accum_cache.sv
// rtl/grad_accum_cache.sv - gradient accumulation cache: lookup, saturating accumulate, evict and flush walk
module grad_accum_cache
    import grad_cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int GRAD_W      = 16,
    parameter int ACC_W       = 32,
    parameter int DEPTH       = 256,
    parameter int NUM_WAYS    = 4,
    parameter int CNT_W       = 8,
    parameter int MAX_UPDATES = 255,
    parameter int THRESHOLD   = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [GRAD_W-1:0]      in_grad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [ACC_W-1:0]       out_accum,
    output logic [1:0]             out_cause,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int NUM_SETS = DEPTH / NUM_WAYS;
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int OCC_W    = IDX_W + 1;

    if (DEPTH % NUM_WAYS != 0) begin : g_bad_depth
        $fatal(1, "grad_accum_cache: DEPTH must be a multiple of NUM_WAYS");
    end
    if (ACC_W < GRAD_W || ACC_W > SAT_W - 2) begin : g_bad_acc
        $fatal(1, "grad_accum_cache: ACC_W must be >= GRAD_W and <= 62");
    end
    if (MAX_UPDATES < 1 || MAX_UPDATES > (1 << CNT_W) - 1) begin : g_bad_max
        $fatal(1, "grad_accum_cache: MAX_UPDATES out of range for CNT_W");
    end
    if (NUM_WAYS < 2 || (NUM_WAYS & (NUM_WAYS - 1)) != 0 ||
        NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_geom
        $fatal(1, "grad_accum_cache: NUM_WAYS and DEPTH/NUM_WAYS must be powers of two >= 2");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ACC_W-1:0]  out_accum_q, out_accum_d;
    ev_cause_e         out_cause_q, out_cause_d;

    logic [SET_W-1:0]    rd_set, wr_set, walk_set;
    logic [NUM_WAYS-1:0] rd_valid;
    logic [ADDR_W-1:0]   rd_tag [NUM_WAYS];
    logic [ACC_W-1:0]    rd_acc [NUM_WAYS];
    logic [CNT_W-1:0]    rd_cnt [NUM_WAYS];
    logic [WAY_W-1:0]    rd_rr, wr_way, walk_way;
    logic                wr_en, wr_valid, rr_inc;
    logic [ADDR_W-1:0]   wr_tag;
    logic [ACC_W-1:0]    wr_acc;
    logic [CNT_W-1:0]    wr_cnt;

    logic                    can_load, accept;
    logic                    hit, free, over;
    logic [WAY_W-1:0]        hit_way, free_way;
    logic signed [SAT_W-1:0] grad_ext, acc_ext, sum, mag;
    logic [CNT_W-1:0]        new_cnt;
    logic                    emit;
    logic [ADDR_W-1:0]       em_addr;
    logic [ACC_W-1:0]        em_acc;
    ev_cause_e               em_cause;

    grad_cache_store #(
        .ADDR_W  (ADDR_W),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W),
        .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_set  (rd_set),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_acc  (rd_acc),
        .rd_cnt  (rd_cnt),
        .rd_rr   (rd_rr),
        .wr_en   (wr_en),
        .wr_set  (wr_set),
        .wr_way  (wr_way),
        .wr_valid(wr_valid),
        .wr_tag  (wr_tag),
        .wr_acc  (wr_acc),
        .wr_cnt  (wr_cnt),
        .rr_inc  (rr_inc)
    );

    assign walk_set = idx_q[IDX_W-1:WAY_W];
    assign walk_way = idx_q[WAY_W-1:0];
    assign rd_set   = (state_q == ST_FLUSH) ? walk_set : in_addr[SET_W-1:0];
    assign can_load = !out_valid_q || out_ready;
    // flush_req wins over a simultaneous update; rst_n keeps the port quiet in reset.
    assign in_ready = rst_n && (state_q == ST_RUN) && !flush_req && can_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (rd_valid[w] && rd_tag[w] == in_addr) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        grad_ext = {{(SAT_W-GRAD_W){in_grad[GRAD_W-1]}}, in_grad};
        acc_ext  = {{(SAT_W-ACC_W){rd_acc[hit_way][ACC_W-1]}}, rd_acc[hit_way]};
        sum      = hit ? sat_add(acc_ext, grad_ext, ACC_W) : grad_ext;
        mag      = sum[SAT_W-1] ? -sum : sum;
        over     = mag >= SAT_W'(THRESHOLD);
        new_cnt  = hit ? rd_cnt[hit_way] + CNT_W'(1) : CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q && !out_ready;
        out_addr_d  = out_addr_q;
        out_accum_d = out_accum_q;
        out_cause_d = out_cause_q;
        wr_en       = 1'b0;
        wr_set      = in_addr[SET_W-1:0];
        wr_way      = hit ? hit_way : free_way;
        wr_valid    = 1'b1;
        wr_tag      = in_addr;
        wr_acc      = sum[ACC_W-1:0];
        wr_cnt      = new_cnt;
        rr_inc      = 1'b0;
        flush_done  = 1'b0;
        emit        = 1'b0;
        em_addr     = in_addr;
        em_acc      = sum[ACC_W-1:0];
        em_cause    = EV_THRESH;

        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    idx_d   = '0;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (hit || free) begin
                        if (over || new_cnt == CNT_W'(MAX_UPDATES)) begin
                            emit     = 1'b1;
                            em_cause = over ? EV_THRESH : EV_MAXUPD;
                            wr_valid = 1'b0;
                            if (hit) begin
                                occ_d = occ_q - OCC_W'(1);
                            end
                        end else if (!hit) begin
                            occ_d = occ_q + OCC_W'(1);
                        end
                    end else begin
                        // Set full: the round-robin victim leaves, the new entry takes its way.
                        wr_way   = rd_rr;
                        rr_inc   = 1'b1;
                        emit     = 1'b1;
                        em_addr  = rd_tag[rd_rr];
                        em_acc   = rd_acc[rd_rr];
                        em_cause = EV_CONFLICT;
                    end
                end
            end
            ST_FLUSH: begin
                if (can_load) begin
                    if (rd_valid[walk_way]) begin
                        emit     = 1'b1;
                        em_addr  = rd_tag[walk_way];
                        em_acc   = rd_acc[walk_way];
                        em_cause = EV_FLUSH;
                        wr_en    = 1'b1;
                        wr_set   = walk_set;
                        wr_way   = walk_way;
                        wr_valid = 1'b0;
                        occ_d    = occ_q - OCC_W'(1);
                    end
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_FDONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FDONE: begin
                if (!out_valid_q) begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_addr_d  = em_addr;
            out_accum_d = em_acc;
            out_cause_d = em_cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_accum_q <= '0;
            out_cause_q <= EV_THRESH;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_accum_q <= out_accum_d;
            out_cause_q <= out_cause_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_accum  = out_accum_q;
    assign out_cause  = out_cause_q;
    assign flush_busy = (state_q == ST_FLUSH);
    assign occupancy  = occ_q;

endmodule
